// File: rtl/sell_pkg.sv
// Shared constants for the vending transaction controller: state codes,
// register map addresses and event bit positions.
package sell_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CREDIT   = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_CHANGE   = 3'd4;

  localparam logic [2:0] ADDR_CREDIT   = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;
  localparam logic [2:0] ADDR_EVENTS   = 3'd7;

  localparam int EV_DISPENSED    = 0;
  localparam int EV_NO_FUNDS     = 1;
  localparam int EV_CHANGE_TAKEN = 2;
  localparam int EV_COIN_REJECT  = 3;
  localparam int EV_TIMEOUT      = 4;
  localparam int NUM_EVENTS      = 5;

endpackage

// File: rtl/sell_edge_sync.sv
// Two-flop synchronizer for a raw button level plus a one-cycle pulse on its
// synchronized rising edge (pulse appears two clocks after the input rises).
module sell_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[1:0], din};
  end

  // sync[2] is the previous synchronized level
  assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/sell_txn_ctrl.sv
// Vending transaction controller: coin credit, purchase check, dispense/change handshakes and CSR block.
// Defining SELL_TIMEOUT_EN adds a dispense watchdog that refunds the item price and moves to CHANGE.
module sell_txn_ctrl
  import sell_pkg::*;
#(
  parameter int NUM_ITEMS      = 4,
  parameter int CREDIT_W       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  output logic                coin_reject,
  input  logic [1:0]          item_sel,
  input  logic                confirm_buy,
  input  logic                cancel,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  input  logic                dispense_done,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  input  logic                change_ack,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic                irq
);

  logic [2:0]            state, state_nxt;
  logic [CREDIT_W-1:0]   credit, credit_nxt;
  logic [1:0]            item, item_nxt;
  logic [CREDIT_W-1:0]   price [NUM_ITEMS];
  logic [CREDIT_W-1:0]   item_price;
  logic [CREDIT_W:0]     coin_sum;
  logic [CREDIT_W-1:0]   coin_sat;
  logic [4:0]            irq_mask;
  logic [NUM_EVENTS-1:0] events, ev_set;
  logic                  reject_nxt, confirm_rise, cancel_rise, wr_en, ev_clear;

  sell_edge_sync u_confirm_sync (.clk(clk), .reset_n(reset_n), .din(confirm_buy), .rise(confirm_rise));
  sell_edge_sync u_cancel_sync  (.clk(clk), .reset_n(reset_n), .din(cancel),      .rise(cancel_rise));

  assign item_price = price[item];
  assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
  assign coin_sat   = coin_sum[CREDIT_W] ? '1 : coin_sum[CREDIT_W-1:0];

`ifdef SELL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_cnt;
  logic                wd_expired;
  logic [CREDIT_W:0]   refund_sum;
  logic [CREDIT_W-1:0] refund_sat;

  // expires on the TIMEOUT_CYCLES-th cycle spent in DISPENSE
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign refund_sum = {1'b0, credit} + {1'b0, item_price};
  assign refund_sat = refund_sum[CREDIT_W] ? '1 : refund_sum[CREDIT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wd_cnt <= '0;
    else if (state == ST_DISPENSE) wd_cnt <= wd_cnt + WD_W'(1);
    else                          wd_cnt <= '0;
  end
`endif

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    item_nxt   = item;
    ev_set     = '0;
    reject_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          credit_nxt = coin_sat;
          state_nxt  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        // a coin arriving with the confirm edge is counted before CHECK
        if (coin_valid) credit_nxt = coin_sat;
        if (cancel_rise) begin
          state_nxt = ST_CHANGE;
        end else if (confirm_rise) begin
          state_nxt = ST_CHECK;
          item_nxt  = item_sel;
        end
      end
      ST_CHECK: begin
        if (item_price != '0 && credit >= item_price) begin
          credit_nxt = credit - item_price;
          state_nxt  = ST_DISPENSE;
        end else begin
          ev_set[EV_NO_FUNDS] = 1'b1;
          state_nxt           = ST_CREDIT;
        end
      end
      ST_DISPENSE: begin
        if (dispense_done) begin
          ev_set[EV_DISPENSED] = 1'b1;
          state_nxt            = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end
`ifdef SELL_TIMEOUT_EN
        else if (wd_expired) begin
          credit_nxt         = refund_sat;
          ev_set[EV_TIMEOUT] = 1'b1;
          state_nxt          = ST_CHANGE;
        end
`endif
      end
      ST_CHANGE: begin
        if (change_ack) begin
          credit_nxt              = '0;
          ev_set[EV_CHANGE_TAKEN] = 1'b1;
          state_nxt               = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (coin_valid && (state == ST_CHECK || state == ST_DISPENSE || state == ST_CHANGE)) begin
      reject_nxt             = 1'b1;
      ev_set[EV_COIN_REJECT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      credit      <= '0;
      item        <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      item        <= item_nxt;
      coin_reject <= reject_nxt;
    end
  end

  assign wr_en    = chipselect && !write_n;
  assign ev_clear = wr_en && (address == ADDR_EVENTS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) price[i] <= '0;
      irq_mask <= '0;
      events   <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++)
        if (wr_en && address == 3'(i)) price[i] <= CREDIT_W'(writedata);
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[4:0];
      // new events survive a clearing write in the same cycle
      events <= (ev_clear ? '0 : events) | ev_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_CREDIT:   readdata <= 8'(credit);
        ADDR_STATUS:   readdata <= {5'd0, state};
        ADDR_IRQ_MASK: readdata <= {3'd0, irq_mask};
        ADDR_EVENTS:   readdata <= 8'(events);
        default:       readdata <= 8'(price[address[1:0]]);
      endcase
    end
  end

  assign dispense_valid = (state == ST_DISPENSE);
  assign dispense_item  = dispense_valid ? item : '0;
  assign change_valid   = (state == ST_CHANGE);
  assign change_amount  = change_valid ? credit : '0;
  assign irq            = |(events & irq_mask);

endmodule

// File: tb/tb_sell_txn_ctrl.sv
// Scoreboard bench for sell_txn_ctrl: transaction-level model pushes expectations,
// a negedge monitor pops them as dispense/change/reject/readdata responses appear.
module tb_sell_txn_ctrl;
  import sell_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin_valid = 1'b0, confirm_buy = 1'b0, cancel = 1'b0;
  logic [3:0] coin_value = '0;
  logic [1:0] item_sel = '0;
  logic       dispense_done = 1'b0, change_ack = 1'b0;
  logic [2:0] address = '0;
  logic       chipselect = 1'b0, write_n = 1'b1;
  logic [7:0] writedata = '0;
  logic       coin_reject, dispense_valid, change_valid, irq;
  logic [1:0] dispense_item;
  logic [7:0] change_amount, readdata;

  always #5 clk = ~clk;

  sell_txn_ctrl #(.NUM_ITEMS(4), .CREDIT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .item_sel(item_sel), .confirm_buy(confirm_buy), .cancel(cancel),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item), .dispense_done(dispense_done),
    .change_valid(change_valid), .change_amount(change_amount), .change_ack(change_ack),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  int n_vec = 0, n_err = 0;
  int exp_disp[$], exp_chg[$], exp_rej[$], exp_rd[$];
  int m_credit = 0, m_mask = 0, m_ev = 0;
  int m_price[4] = '{0, 0, 0, 0};
  bit m_in_credit = 1'b0;
  bit rd_issue = 1'b0, rd_pend = 1'b0, disp_prev = 1'b0, chg_prev = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int rd_model(int a);
    case (a)
      0, 1, 2, 3: return m_price[a];
      4:          return m_credit;
      5:          return m_in_credit ? int'(ST_CREDIT) : int'(ST_IDLE);
      6:          return m_mask;
      default:    return m_ev;
    endcase
  endfunction

  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (dispense_valid && !disp_prev) begin
      chk("dispense_expected", int'(exp_disp.size() > 0), 1);
      if (exp_disp.size() > 0) chk("dispense_item", int'(dispense_item), exp_disp.pop_front());
    end
    if (change_valid && !chg_prev) begin
      chk("change_expected", int'(exp_chg.size() > 0), 1);
      if (exp_chg.size() > 0) chk("change_amount", int'(change_amount), exp_chg.pop_front());
    end
    if (coin_reject) begin
      chk("coin_reject_expected", int'(exp_rej.size() > 0), 1);
      if (exp_rej.size() > 0) void'(exp_rej.pop_front());
    end
    if (rd_pend) begin
      chk("readdata_expected", int'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0) chk("readdata", int'(readdata), exp_rd.pop_front());
    end
    disp_prev <= dispense_valid;
    chg_prev  <= change_valid;
  end

  task automatic rd(int a);
    address = 3'(a); rd_issue = 1'b1;
    exp_rd.push_back(rd_model(a));
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic wr(int a, int d);
    address = 3'(a); writedata = 8'(d); chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    if (a < 4) m_price[a] = d & 255;
    else if (a == 6) m_mask = d & 31;
    else if (a == 7) m_ev = 0;
  endtask

  task automatic chk_irq();
    chk("irq", int'(irq), int'((m_ev & m_mask) != 0));
  endtask

  task automatic coin(int v);
    coin_valid = 1'b1; coin_value = 4'(v);
    tick();
    coin_valid = 1'b0;
    m_credit = sat(m_credit + v);
    m_in_credit = 1'b1;
  endtask

  task automatic reject_coin();
    coin_valid = 1'b1; coin_value = 4'($urandom_range(1, 15));
    exp_rej.push_back(1);
    tick();
    coin_valid = 1'b0;
    m_ev |= 8;
  endtask

  task automatic wait_sig(int which, string name);
    int n = 0;
    bit ok = 1'b0;
    while (n < 40) begin
      if ((which == 0 && dispense_valid) || (which == 1 && change_valid)) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic finish_change(bit rej);
    wait_sig(1, "wait_change");
    if (rej) reject_coin();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    m_credit = 0; m_ev |= 4; m_in_credit = 1'b0;
  endtask

  // Raise confirm and/or cancel; cv>0 drops a coin on the cycle the edge is acted on.
  task automatic press(bit conf, bit canc, int item, int cv, bit rej);
    bit was_credit;
    was_credit = m_in_credit;
    item_sel = 2'(item); confirm_buy = conf; cancel = canc;
    tick(); tick();
    if (cv > 0) begin coin_valid = 1'b1; coin_value = 4'(cv); end
    tick();
    coin_valid = 1'b0; confirm_buy = 1'b0; cancel = 1'b0;
    if (cv > 0) begin m_credit = sat(m_credit + cv); m_in_credit = 1'b1; end
    if (was_credit && canc) begin
      exp_chg.push_back(m_credit);
      finish_change(rej);
    end else if (was_credit && conf) begin
      if (m_price[item] != 0 && m_credit >= m_price[item]) begin
        m_credit -= m_price[item];
        exp_disp.push_back(item);
        wait_sig(0, "wait_dispense");
        if (rej) reject_coin();
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        m_ev |= 1;
        if (m_credit > 0) begin
          exp_chg.push_back(m_credit);
          finish_change(rej);
        end else begin
          m_in_credit = 1'b0;
        end
      end else begin
        m_ev |= 2;
      end
    end
    tick(); tick();
  endtask

  task automatic timeout_case();
    int n = 0;
    wr(7, 0); wr(2, 5); coin(5);
    item_sel = 2'd2; confirm_buy = 1'b1;
    tick(); tick(); tick();
    confirm_buy = 1'b0;
    m_credit = 0;
    exp_disp.push_back(2);
    wait_sig(0, "wait_dispense_wd");
`ifdef SELL_TIMEOUT_EN
    exp_chg.push_back(5);
    while (!change_valid && n < 40) begin tick(); n++; end
    chk("timeout_cycles", n, 16);
    m_credit = sat(m_credit + 5); m_ev |= 16;
    finish_change(1'b0);
`else
    while (n < 40) begin tick(); n++; end
    chk("still_dispensing", int'(dispense_valid), 1);
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    m_ev |= 1; m_in_credit = 1'b0;
`endif
    tick(); tick();
    rd(7); rd(4);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_coin_reject", int'(coin_reject), 0);
    chk("rst_dispense_valid", int'(dispense_valid), 0);
    chk("rst_dispense_item", int'(dispense_item), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_change_amount", int'(change_amount), 0);
    chk("rst_readdata", int'(readdata), 0);
    chk("rst_irq", int'(irq), 0);
    reset_n = 1'b1;
    tick();
    rd(5); rd(4); rd(1); rd(7);

    // buy item 1 at 5 with 2+4 inserted: change 1, events dispensed+change
    wr(1, 5); coin(2); coin(4);
    press(1'b1, 1'b0, 1, 0, 1'b0);
    rd(7); rd(5);

    // insufficient credit returns to CREDIT with no-funds event
    wr(7, 0); wr(0, 9); coin(3);
    press(1'b1, 1'b0, 0, 0, 1'b0);
    rd(5); rd(7); rd(4);
    press(1'b0, 1'b1, 0, 0, 1'b0);

    // simultaneous confirm and cancel: cancel wins
    wr(7, 0); coin(7);
    press(1'b1, 1'b1, 0, 0, 1'b0);
    rd(7);

    // coin during dispense rejected, irq on masked reject event
    wr(7, 0); wr(6, 8); coin(6);
    press(1'b1, 1'b0, 1, 0, 1'b1);
    chk_irq(); rd(7); rd(4);
    wr(6, 0); wr(7, 0); chk_irq();

    // coin coinciding with the confirm edge counts toward the check
    wr(3, 10); coin(4);
    press(1'b1, 1'b0, 3, 6, 1'b0);
    rd(4); rd(5);

    timeout_case();

    // saturation at 255
    repeat (17) coin(15);
    coin(15);
    rd(4);
    press(1'b0, 1'b1, 0, 0, 1'b0);

    // reset in CHANGE drops outputs immediately
    coin(7);
    cancel = 1'b1;
    tick(); tick(); tick();
    cancel = 1'b0;
    exp_chg.push_back(7);
    wait_sig(1, "wait_change_rst");
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_change_valid", int'(change_valid), 0);
    chk("rst_mid_change_amount", int'(change_amount), 0);
    tick(); tick();
    reset_n = 1'b1;
    m_credit = 0; m_mask = 0; m_ev = 0; m_in_credit = 1'b0;
    for (int i = 0; i < 4; i++) m_price[i] = 0;
    tick();
    rd(4); rd(5); rd(0); rd(6); rd(7);

    for (int i = 0; i < 4; i++) wr(i, $urandom_range(1, 30));
    for (int it = 0; it < 150; it++) begin
      int op;
      int item;
      op   = $urandom_range(0, 9);
      item = $urandom_range(0, 3);
      case (op)
        0, 1, 2: coin($urandom_range(1, 15));
        3, 4:    press(1'b1, 1'b0, item, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0,
                       1'($urandom_range(0, 1)));
        5:       press(1'($urandom_range(0, 1)), 1'b1, item, 0, 1'($urandom_range(0, 1)));
        6:       begin rd($urandom_range(0, 7)); chk_irq(); end
        7:       wr(item, $urandom_range(0, 30));
        8:       wr(6, $urandom_range(0, 31));
        default: begin wr(7, int'($urandom())); rd(7); end
      endcase
    end
    rd(4); rd(5); rd(7); chk_irq();

    repeat (4) tick();
    chk("pending_dispense", exp_disp.size(), 0);
    chk("pending_change", exp_chg.size(), 0);
    chk("pending_reject", exp_rej.size(), 0);
    chk("pending_read", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sell_txn_ctrl.md
SELL_TXN_CTRL -- requirements
Module: sell_txn_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4, number of sellable items (item index width 2).
REQ-002 SHALL have parameter CREDIT_W, default 8, width of credit, price and change values.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, dispense watchdog limit.
REQ-004 SHALL have ports: clk in 1 system clock; reset_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: coin_valid in 1 one-cycle coin strobe; coin_value in 4 coin amount; coin_reject out 1 coin refused.
REQ-006 SHALL have ports: item_sel in 2 selected item; confirm_buy in 1 raw button level; cancel in 1 raw button level.
REQ-007 SHALL have ports: dispense_valid out 1; dispense_item out 2; dispense_done in 1 one-cycle motor completion.
REQ-008 SHALL have ports: change_valid out 1; change_amount out CREDIT_W; change_ack in 1 one-cycle acceptance.
REQ-009 SHALL have ports: address in 3; chipselect in 1; write_n in 1; writedata in 8; readdata out 8 registered; irq out 1.

Function
REQ-010 SHALL double-flop confirm_buy and cancel, acting on the rising edge of the synchronized signal only.
REQ-011 SHALL implement states IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
REQ-012 SHALL, in IDLE or CREDIT, add coin_value to credit on coin_valid, saturating at 2^CREDIT_W-1, and enter/stay in CREDIT.
REQ-013 SHALL, on coin_valid in CHECK, DISPENSE or CHANGE, ignore the coin and pulse coin_reject one cycle later, setting event bit 3.
REQ-014 SHALL, in CREDIT, go to CHANGE on cancel edge; else go to CHECK on confirm edge, latching item_sel; cancel wins on simultaneous edges.
REQ-015 SHALL ignore confirm and cancel edges in IDLE, CHECK, DISPENSE and CHANGE.
REQ-016 SHALL, in CHECK (exactly one cycle), go to DISPENSE with credit -= price if price nonzero and credit >= price; else set event bit 1 and return to CREDIT.
REQ-017 SHALL, when a coin and a confirm edge coincide in CREDIT, include that coin in the credit compared in CHECK.
REQ-018 SHALL hold dispense_valid high with dispense_item stable through DISPENSE until dispense_done; then set event bit 0 and go to CHANGE if credit > 0, else IDLE.
REQ-019 SHALL hold change_valid high with change_amount = credit through CHANGE until change_ack; then clear credit, set event bit 2, go to IDLE.
REQ-020 SHALL map registers: 0-3 price[i] RW; 4 credit RO; 5 status {state[2:0]} RO; 6 irq_mask RW [4:0]; 7 events RW, any write clears all.
REQ-021 SHALL present readdata one cycle after address, unconditionally registered; unused bits read 0.
REQ-022 SHALL give an event set priority over a clearing write in the same cycle.
REQ-023 SHALL drive irq = OR of (events & irq_mask), combinational from registers.

Reset
REQ-024 SHALL, on reset_n low, set state IDLE, credit 0, prices 0, irq_mask 0, events 0, readdata 0, all outputs 0, synchronizer flops 0.
REQ-025 SHALL, on reset mid-DISPENSE or mid-CHANGE, drop dispense_valid/change_valid immediately and discard credit.

Configuration
REQ-026 SHALL, with SELL_TIMEOUT_EN defined, abort DISPENSE after TIMEOUT_CYCLES without dispense_done: credit += item price (saturating), set event bit 4, go to CHANGE.
REQ-027 SHALL, without SELL_TIMEOUT_EN, wait in DISPENSE indefinitely, contain no watchdog counter, and read event bit 4 as 0.

Structure
REQ-028 SHALL take state encoding, register address constants and event bit indices from shared package sell_pkg.
REQ-029 SHALL instantiate sub-module sell_edge_sync (2-flop sync plus rising-edge pulse) once each for confirm_buy and cancel.

Verification
REQ-030 SHALL cover: price[1]=5, coins 2+4, item_sel=1, confirm -> dispense_item=1, after done change_amount=1, events=0x05.
REQ-031 SHALL cover: price[0]=9, coin 3, confirm -> state back to CREDIT, event bit 1, no dispense_valid.
REQ-032 SHALL cover: coin 7 then confirm and cancel same cycle -> CHANGE, change_amount=7, no dispense.
REQ-033 SHALL cover: coin_valid during DISPENSE -> coin_reject pulse, credit unchanged, irq high when mask=0x08.
REQ-034 SHALL cover (SELL_TIMEOUT_EN, TIMEOUT_CYCLES=16): price 5, credit 5, no dispense_done -> after 16 cycles CHANGE with change_amount=5, event bit 4.
REQ-035 SHALL cover: credit 255 plus coin 15 -> credit stays 255; reset asserted in CHANGE -> outputs 0 same cycle.
